// File: rtl/ps2_key_pkg.sv
// Shared encodings for the PS/2 key decoder: key classes, operators,
// Set-2 scancodes, decode FSM states and the scancode-to-key lookup.
package ps2_key_pkg;

    localparam logic [2:0] KC_DIGIT = 3'd0;
    localparam logic [2:0] KC_OP    = 3'd1;
    localparam logic [2:0] KC_ENTER = 3'd2;
    localparam logic [2:0] KC_CLEAR = 3'd3;
    localparam logic [2:0] KC_BKSP  = 3'd4;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;

    localparam logic [7:0] SC_E0 = 8'hE0;
    localparam logic [7:0] SC_F0 = 8'hF0;
    localparam logic [7:0] SC_E1 = 8'hE1;

    // 9-bit codes are {ext, byte}
    localparam logic [8:0] SC_D0       = 9'h070;
    localparam logic [8:0] SC_D1       = 9'h069;
    localparam logic [8:0] SC_D2       = 9'h072;
    localparam logic [8:0] SC_D3       = 9'h07A;
    localparam logic [8:0] SC_D4       = 9'h06B;
    localparam logic [8:0] SC_D5       = 9'h073;
    localparam logic [8:0] SC_D6       = 9'h074;
    localparam logic [8:0] SC_D7       = 9'h06C;
    localparam logic [8:0] SC_D8       = 9'h075;
    localparam logic [8:0] SC_D9       = 9'h07D;
    localparam logic [8:0] SC_ADD      = 9'h079;
    localparam logic [8:0] SC_SUB      = 9'h07B;
    localparam logic [8:0] SC_MUL      = 9'h07C;
    localparam logic [8:0] SC_DIV      = 9'h14A;
    localparam logic [8:0] SC_ENTER    = 9'h05A;
    localparam logic [8:0] SC_KP_ENTER = 9'h15A;
    localparam logic [8:0] SC_ESC      = 9'h076;
    localparam logic [8:0] SC_BKSP     = 9'h066;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXTBRK,
        ST_SKIP
    } state_t;

    typedef struct packed {
        logic       hit;
        logic [2:0] kclass;
        logic [3:0] code;
    } key_info_t;

    function automatic key_info_t map_key(input logic [8:0] sc);
        key_info_t k;
        k     = '0;
        k.hit = 1'b1;
        case (sc)
            SC_D0:       k.code = 4'd0;
            SC_D1:       k.code = 4'd1;
            SC_D2:       k.code = 4'd2;
            SC_D3:       k.code = 4'd3;
            SC_D4:       k.code = 4'd4;
            SC_D5:       k.code = 4'd5;
            SC_D6:       k.code = 4'd6;
            SC_D7:       k.code = 4'd7;
            SC_D8:       k.code = 4'd8;
            SC_D9:       k.code = 4'd9;
            SC_ADD:      begin k.kclass = KC_OP; k.code = OP_ADD; end
            SC_SUB:      begin k.kclass = KC_OP; k.code = OP_SUB; end
            SC_MUL:      begin k.kclass = KC_OP; k.code = OP_MUL; end
            SC_DIV:      begin k.kclass = KC_OP; k.code = OP_DIV; end
            SC_ENTER,
            SC_KP_ENTER: k.kclass = KC_ENTER;
            SC_ESC:      k.kclass = KC_CLEAR;
            SC_BKSP:     k.kclass = KC_BKSP;
            default:     k.hit = 1'b0;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/key_event_fifo.sv
// Small synchronous event FIFO; a push while full only lands if a pop
// frees a slot in the same cycle.
module key_event_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [6:0] din,
    input  logic       pop,
    output logic [6:0] dout,
    output logic       full,
    output logic       empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [6:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// Turns the Set-2 scancode byte stream into one event per key press,
// with prefix handling, typematic repeat suppression and an event FIFO.
module ps2_key_decoder
    import ps2_key_pkg::*;
#(
    parameter int unsigned DEPTH           = 4,
    parameter bit          REPEAT_SUPPRESS = 1'b1
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic [7:0] iBYTE,
    input  logic       iBYTE_VALID,
    output logic       oKEY_VALID,
    input  logic       iKEY_READY,
    output logic [2:0] oKEY_CLASS,
    output logic [3:0] oKEY_CODE,
    output logic       oOVERFLOW
);

    state_t     state, state_nxt;
    logic [2:0] skip_cnt, skip_cnt_nxt;
    logic [8:0] held_code;
    logic       held_valid;
    logic       make_vld;
    logic       brk_vld;
    logic [8:0] scan;
    key_info_t  key;
    logic       is_repeat;
    logic       push;
    logic       pop;
    logic       fifo_full;
    logic       fifo_empty;
    logic [6:0] head;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state    <= ST_IDLE;
            skip_cnt <= '0;
        end else begin
            state    <= state_nxt;
            skip_cnt <= skip_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        skip_cnt_nxt = skip_cnt;
        make_vld     = 1'b0;
        brk_vld      = 1'b0;
        scan         = {1'b0, iBYTE};
        if (iBYTE_VALID) begin
            case (state)
                ST_IDLE: begin
                    if (iBYTE == SC_E0) state_nxt = ST_EXT;
                    else if (iBYTE == SC_F0) state_nxt = ST_BRK;
                    else if (iBYTE == SC_E1) begin
                        state_nxt    = ST_SKIP;
                        skip_cnt_nxt = 3'd7;
                    end else make_vld = 1'b1;
                end
                ST_EXT: begin
                    if (iBYTE == SC_F0) state_nxt = ST_EXTBRK;
                    else begin
                        make_vld  = 1'b1;
                        scan      = {1'b1, iBYTE};
                        state_nxt = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    brk_vld   = 1'b1;
                    state_nxt = ST_IDLE;
                end
                ST_EXTBRK: begin
                    brk_vld   = 1'b1;
                    scan      = {1'b1, iBYTE};
                    state_nxt = ST_IDLE;
                end
                ST_SKIP: begin
                    skip_cnt_nxt = skip_cnt - 3'd1;
                    if (skip_cnt == 3'd1) state_nxt = ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    assign key       = map_key(scan);
    assign is_repeat = REPEAT_SUPPRESS && held_valid && (held_code == scan);
    assign push      = make_vld && key.hit && !is_repeat;
    assign pop       = oKEY_VALID && iKEY_READY;

    // held_code only ever holds mapped codes, so unmapped breaks never match
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            held_code  <= '0;
            held_valid <= 1'b0;
        end else if (push) begin
            held_code  <= scan;
            held_valid <= 1'b1;
        end else if (brk_vld && held_valid && (scan == held_code)) begin
            held_valid <= 1'b0;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) oOVERFLOW <= 1'b0;
        else if (push && fifo_full && !pop) oOVERFLOW <= 1'b1;
    end

    key_event_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (iCLK),
        .rst   (iRST),
        .push  (push),
        .din   ({key.kclass, key.code}),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Head is masked while empty so the outputs read 0 out of reset
    assign oKEY_VALID = !fifo_empty;
    assign oKEY_CLASS = fifo_empty ? 3'd0 : head[6:4];
    assign oKEY_CODE  = fifo_empty ? 4'd0 : head[3:0];

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder; a second instance runs with
// repeat suppression disabled on the same byte stream.
module tb_ps2_key_decoder;

    logic       iCLK = 1'b0;
    logic       iRST = 1'b1;
    logic [7:0] iBYTE = 8'h00;
    logic       iBYTE_VALID = 1'b0;
    logic       iKEY_READY = 1'b1;
    logic       kv, kv_nr;
    logic [2:0] kc, kc_nr;
    logic [3:0] kk, kk_nr;
    logic       ovf, ovf_nr;

    int n_checks = 0;
    int n_pass   = 0;
    int vcyc     = 0;
    logic [6:0] evq[$];
    logic [6:0] evq_nr[$];

    always #5 iCLK = ~iCLK;

    ps2_key_decoder #(.DEPTH(4), .REPEAT_SUPPRESS(1'b1)) dut (
        .iCLK(iCLK), .iRST(iRST), .iBYTE(iBYTE), .iBYTE_VALID(iBYTE_VALID),
        .oKEY_VALID(kv), .iKEY_READY(iKEY_READY), .oKEY_CLASS(kc),
        .oKEY_CODE(kk), .oOVERFLOW(ovf)
    );

    ps2_key_decoder #(.DEPTH(4), .REPEAT_SUPPRESS(1'b0)) dut_nr (
        .iCLK(iCLK), .iRST(iRST), .iBYTE(iBYTE), .iBYTE_VALID(iBYTE_VALID),
        .oKEY_VALID(kv_nr), .iKEY_READY(iKEY_READY), .oKEY_CLASS(kc_nr),
        .oKEY_CODE(kk_nr), .oOVERFLOW(ovf_nr)
    );

    // Record every accepted event, sampled mid-cycle before the popping edge
    always @(negedge iCLK) begin
        if (!iRST && kv && iKEY_READY)    evq.push_back({kc, kk});
        if (!iRST && kv_nr && iKEY_READY) evq_nr.push_back({kc_nr, kk_nr});
        if (!iRST && kv) vcyc++;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge iCLK); #1;
        iBYTE       = b;
        iBYTE_VALID = 1'b1;
        @(posedge iCLK); #1;
        iBYTE_VALID = 1'b0;
    endtask

    task automatic send_seq(input logic [7:0] s[]);
        foreach (s[i]) send_byte(s[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge iCLK);
        @(negedge iCLK);
    endtask

    task automatic clear_log();
        evq.delete();
        evq_nr.delete();
        vcyc = 0;
    endtask

    task automatic check_ev(input string tag, input logic [6:0] ev,
                            input int exp_class, input int exp_code);
        check({tag, "_class"}, int'(ev[6:4]), exp_class);
        check({tag, "_code"},  int'(ev[3:0]), exp_code);
    endtask

    initial begin
        logic [7:0] seq[];

        iRST = 1'b1;
        idle(3);
        check("rst_valid", int'(kv), 0);
        check("rst_class", int'(kc), 0);
        check("rst_code",  int'(kk), 0);
        check("rst_ovf",   int'(ovf), 0);
        @(posedge iCLK); #1;
        iRST = 1'b0;
        idle(2);

        // 1: press and release digit 1
        clear_log();
        seq = '{8'h69, 8'hF0, 8'h69};
        send_seq(seq);
        idle(4);
        check("t1_count", evq.size(), 1);
        if (evq.size() > 0) check_ev("t1_ev", evq[0], 0, 1);
        check("t1_valid_cycles", vcyc, 1);

        // 2: typematic repeat of digit 3
        clear_log();
        seq = '{8'h7A, 8'h7A, 8'h7A, 8'hF0, 8'h7A, 8'h7A};
        send_seq(seq);
        idle(4);
        check("t2_count", evq.size(), 2);
        if (evq.size() > 1) begin
            check_ev("t2_ev0", evq[0], 0, 3);
            check_ev("t2_ev1", evq[1], 0, 3);
        end
        check("t2_count_nr", evq_nr.size(), 4);

        // 3: extended keys; E0 4A is DIV, a plain 4A would be unmapped
        clear_log();
        seq = '{8'hE0, 8'h4A};
        send_seq(seq);
        idle(3);
        check("t3_div_only", evq.size(), 1);
        seq = '{8'hE0, 8'hF0, 8'h4A, 8'h5A, 8'hF0, 8'h5A, 8'hE0, 8'h5A};
        send_seq(seq);
        idle(4);
        check("t3_count", evq.size(), 3);
        if (evq.size() > 2) begin
            check_ev("t3_div",   evq[0], 1, 3);
            check_ev("t3_enter", evq[1], 2, 0);
            check_ev("t3_kpent", evq[2], 2, 0);
        end

        // 4: Pause sequence swallowed, then Esc
        clear_log();
        seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h76};
        send_seq(seq);
        idle(4);
        check("t4_count", evq.size(), 1);
        if (evq.size() > 0) check_ev("t4_clear", evq[0], 3, 0);
        check("t4_count_nr", evq_nr.size(), 1);

        // 5: consumer stalled, six digit presses into a depth-4 FIFO
        clear_log();
        iKEY_READY = 1'b0;
        seq = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73};
        send_seq(seq);
        idle(3);
        check("t5_valid", int'(kv), 1);
        check("t5_head_class", int'(kc), 0);
        check("t5_head_code", int'(kk), 0);
        check("t5_ovf", int'(ovf), 1);
        check("t5_ovf_nr", int'(ovf_nr), 1);
        @(posedge iCLK); #1;
        iKEY_READY = 1'b1;
        idle(8);
        check("t5_count", evq.size(), 4);
        for (int i = 0; i < 4; i++)
            if (evq.size() > i) check_ev($sformatf("t5_ev%0d", i), evq[i], 0, i);
        check("t5_valid_drop", int'(kv), 0);
        check("t5_ovf_sticky", int'(ovf), 1);

        // 6: reset mid-prefix discards the prefix, held key and overflow
        clear_log();
        seq = '{8'hE0, 8'hF0};
        send_seq(seq);
        @(posedge iCLK); #1;
        iRST = 1'b1;
        idle(2);
        @(posedge iCLK); #1;
        iRST = 1'b0;
        @(negedge iCLK);
        check("t6_ovf", int'(ovf), 0);
        check("t6_empty", int'(kv), 0);
        send_byte(8'h73);
        idle(4);
        check("t6_count", evq.size(), 1);
        if (evq.size() > 0) check_ev("t6_ev", evq[0], 0, 5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
